// File: rtl/sm3_blk_collect_pkg.sv
// sm3_blk_collect_pkg: shared configuration for the SM3 block collector.
//   SM3_BLK_W    - compression block width (512)
//   SM3_INPT_DW  - default padded-stream word width (32 or 64)
//   NUM_BUF      - number of ping-pong block buffers
//   buf_st_e     - per-buffer occupancy state
//   beats_of()   - beats per block for a given stream width
package sm3_blk_collect_pkg;
  localparam int SM3_BLK_W   = 512;
  localparam int SM3_INPT_DW = 64;
  localparam int NUM_BUF     = 2;

  typedef enum logic [1:0] {
    BUF_FREE = 2'd0,
    BUF_FILL = 2'd1,
    BUF_FULL = 2'd2
  } buf_st_e;

  function automatic int beats_of(input int dw);
    return SM3_BLK_W / dw;
  endfunction
endpackage

// File: rtl/sm3_blk_collect_if.sv
// sm3_blk_collect_if: padder stream in, assembled block out, sticky errors.
//   slave  - the collector (consumes pad_*, produces blk_* / err_*)
//   master - the environment (padder + compression core)
interface sm3_blk_collect_if
  import sm3_blk_collect_pkg::*;
#(
  parameter int INPT_DW = SM3_INPT_DW
);
  logic [INPT_DW-1:0]   pad_d_i;
  logic                 pad_vld_i;
  logic                 pad_lst_i;
  logic                 pad_ena_o;
  logic [SM3_BLK_W-1:0] blk_d_o;
  logic                 blk_vld_o;
  logic                 blk_lst_o;
  logic                 blk_rdy_i;
  logic                 err_algn_o;
  logic                 err_ovf_o;

  modport slave (
    input  pad_d_i, pad_vld_i, pad_lst_i, blk_rdy_i,
    output pad_ena_o, blk_d_o, blk_vld_o, blk_lst_o, err_algn_o, err_ovf_o
  );

  modport master (
    output pad_d_i, pad_vld_i, pad_lst_i, blk_rdy_i,
    input  pad_ena_o, blk_d_o, blk_vld_o, blk_lst_o, err_algn_o, err_ovf_o
  );
endinterface

// File: rtl/sm3_blk_buf.sv
// sm3_blk_buf: one 512-bit block buffer.
//   wr_en/slot/wr_d - write one beat into slot (slot 0 = bits 511 downward)
//   close/lst_in    - this write finishes the block; capture the message-last flag
//   free            - block consumed, return to FREE
//   blk_d/blk_lst   - stored block and its last flag
//   st/st_nxt       - current and next occupancy state
module sm3_blk_buf
  import sm3_blk_collect_pkg::*;
#(
  parameter  int INPT_DW = SM3_INPT_DW,
  localparam int BEATS   = beats_of(INPT_DW),
  localparam int SLOT_W  = $clog2(BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [SLOT_W-1:0]    slot,
  input  logic [INPT_DW-1:0]   wr_d,
  input  logic                 close,
  input  logic                 lst_in,
  input  logic                 free,
  output logic [SM3_BLK_W-1:0] blk_d,
  output logic                 blk_lst,
  output buf_st_e              st,
  output buf_st_e              st_nxt
);
  // Writes never target a FULL buffer and free only hits a FULL one,
  // so the two never collide.
  always_comb begin
    st_nxt = st;
    if (free)       st_nxt = BUF_FREE;
    else if (wr_en) st_nxt = close ? BUF_FULL : BUF_FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= BUF_FREE;
      blk_d   <= '0;
      blk_lst <= 1'b0;
    end else begin
      st <= st_nxt;
      if (wr_en) begin
        // The first beat of a block zeroes every other slot, so a block
        // closed early by a misplaced last beat carries a zero tail.
        for (int s = 0; s < BEATS; s++) begin
          if (SLOT_W'(s) == slot)
            blk_d[SM3_BLK_W-1-s*INPT_DW -: INPT_DW] <= wr_d;
          else if (slot == '0)
            blk_d[SM3_BLK_W-1-s*INPT_DW -: INPT_DW] <= '0;
        end
        if (close) blk_lst <= lst_in;
      end
    end
  end
endmodule

// File: rtl/sm3_blk_collect.sv
// sm3_blk_collect: packs the padded SM3 stream into 512-bit blocks using
// two ping-pong buffers and hands them to the compression core.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of sm3_blk_collect_if (pad stream in, blocks out,
//              padder back-pressure, sticky alignment/overflow errors)
module sm3_blk_collect
  import sm3_blk_collect_pkg::*;
#(
  parameter int INPT_DW = SM3_INPT_DW
) (
  input  logic             clk,
  input  logic             rst,
  sm3_blk_collect_if.slave bus
);
  localparam int BEATS  = beats_of(INPT_DW);
  localparam int SLOT_W = $clog2(BEATS);

  logic                                wr_sel, rd_sel;
  logic [SLOT_W-1:0]                   beat_cnt;
  logic [NUM_BUF-1:0][SM3_BLK_W-1:0]   buf_d;
  logic [NUM_BUF-1:0]                  buf_lst, buf_wr, buf_free;
  buf_st_e                             buf_st     [NUM_BUF];
  buf_st_e                             buf_st_nxt [NUM_BUF];
  logic                                at_end, wr_full, wr_ok, close, hs, wr_sel_nxt;

  assign at_end     = (beat_cnt == SLOT_W'(BEATS-1));
  assign wr_full    = (buf_st[wr_sel] == BUF_FULL);
  assign wr_ok      = bus.pad_vld_i && !wr_full;
  // A misplaced last beat still closes the block so the next message
  // starts on a block boundary.
  assign close      = wr_ok && (at_end || bus.pad_lst_i);
  assign hs         = bus.blk_vld_o && bus.blk_rdy_i;
  assign wr_sel_nxt = close ? ~wr_sel : wr_sel;

  for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
    assign buf_wr[b]   = wr_ok && (wr_sel == 1'(b));
    assign buf_free[b] = hs && (rd_sel == 1'(b));

    sm3_blk_buf #(.INPT_DW(INPT_DW)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (buf_wr[b]),
      .slot    (beat_cnt),
      .wr_d    (bus.pad_d_i),
      .close   (close),
      .lst_in  (bus.pad_lst_i),
      .free    (buf_free[b]),
      .blk_d   (buf_d[b]),
      .blk_lst (buf_lst[b]),
      .st      (buf_st[b]),
      .st_nxt  (buf_st_nxt[b])
    );
  end

  assign bus.blk_vld_o = (buf_st[rd_sel] == BUF_FULL);
  assign bus.blk_d_o   = buf_d[rd_sel];
  assign bus.blk_lst_o = bus.blk_vld_o && buf_lst[rd_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel         <= 1'b0;
      rd_sel         <= 1'b0;
      beat_cnt       <= '0;
      bus.pad_ena_o  <= 1'b0;
      bus.err_algn_o <= 1'b0;
      bus.err_ovf_o  <= 1'b0;
    end else begin
      if (close) begin
        beat_cnt <= '0;
        wr_sel   <= ~wr_sel;
      end else if (wr_ok) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (hs) rd_sel <= ~rd_sel;
      if (bus.pad_vld_i && wr_full)             bus.err_ovf_o  <= 1'b1;
      if (wr_ok && bus.pad_lst_i && !at_end)    bus.err_algn_o <= 1'b1;
      // Look ahead at the buffer the next beat will land in, including this
      // cycle's write and handshake; a FILL target keeps enable high.
      bus.pad_ena_o <= (buf_st_nxt[wr_sel_nxt] != BUF_FULL);
    end
  end
endmodule

// File: tb/tb_sm3_blk_collect.sv
// tb_sm3_blk_collect: randomized + directed bench for sm3_blk_collect (64b
// stream). A queue-of-blocks reference model predicts every output each cycle.
module tb_sm3_blk_collect;
  import sm3_blk_collect_pkg::*;

  localparam int DW    = 64;
  localparam int BEATS = SM3_BLK_W / DW;
  localparam logic [SM3_BLK_W-1:0] ABC_BLK = {64'h6162638000000000, 384'h0, 64'h18};
  localparam logic [SM3_BLK_W-1:0] PAD_BLK = {64'h8000000000000000, 384'h0, 64'h200};

  typedef struct {
    logic [SM3_BLK_W-1:0] d;
    logic                 lst;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sm3_blk_collect_if #(.INPT_DW(DW)) bus ();
  sm3_blk_collect #(.INPT_DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: completed-but-unconsumed blocks plus the block in progress
  blk_t                 mq[$];
  logic [SM3_BLK_W-1:0] mcur;
  int                   mcnt;
  logic                 malgn, movf, mena;

  task automatic chk(input string tag, input logic [SM3_BLK_W-1:0] got,
                     input logic [SM3_BLK_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit hs, both_full;
    blk_t nb;
    if (rst) begin
      mq.delete();
      mcur = '0; mcnt = 0; malgn = 0; movf = 0; mena = 0;
      return;
    end
    hs        = (mq.size() > 0) && bus.blk_rdy_i;
    both_full = (mq.size() == 2);
    if (bus.pad_vld_i) begin
      if (both_full) movf = 1;
      else begin
        mcur[SM3_BLK_W-1-mcnt*DW -: DW] = bus.pad_d_i;
        if (mcnt == BEATS-1 || bus.pad_lst_i) begin
          if (mcnt != BEATS-1) malgn = 1;
          nb.d = mcur; nb.lst = bus.pad_lst_i;
          mq.push_back(nb);
          mcur = '0; mcnt = 0;
        end else mcnt++;
      end
    end
    if (hs) void'(mq.pop_front());
    mena = (mq.size() < 2);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("blk_vld", SM3_BLK_W'(bus.blk_vld_o), SM3_BLK_W'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("blk_d", bus.blk_d_o, mq[0].d);
      chk("blk_lst", SM3_BLK_W'(bus.blk_lst_o), SM3_BLK_W'(mq[0].lst));
    end
    chk("pad_ena", SM3_BLK_W'(bus.pad_ena_o), SM3_BLK_W'(mena));
    chk("err_algn", SM3_BLK_W'(bus.err_algn_o), SM3_BLK_W'(malgn));
    chk("err_ovf", SM3_BLK_W'(bus.err_ovf_o), SM3_BLK_W'(movf));
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    bus.pad_d_i = d; bus.pad_vld_i = 1'b1; bus.pad_lst_i = l;
    tick();
    bus.pad_vld_i = 1'b0; bus.pad_lst_i = 1'b0;
  endtask

  task automatic wait_ena();
    int k = 0;
    while (!bus.pad_ena_o && k < 200) begin tick(); k++; end
    chk("ena_wait", SM3_BLK_W'(bus.pad_ena_o), SM3_BLK_W'(1));
  endtask

  task automatic rand_blk(input logic l);
    wait_ena();
    for (int i = 0; i < BEATS; i++) beat({$urandom, $urandom}, l && (i == BEATS-1));
  endtask

  task automatic send_abc();
    wait_ena();
    beat(64'h6162638000000000, 1'b0);
    for (int i = 1; i < BEATS-1; i++) beat('0, 1'b0);
    beat(64'h18, 1'b1);
    chk("abc_vld", SM3_BLK_W'(bus.blk_vld_o), SM3_BLK_W'(1));
    chk("abc_d", bus.blk_d_o, ABC_BLK);
    chk("abc_lst", SM3_BLK_W'(bus.blk_lst_o), SM3_BLK_W'(1));
  endtask

  initial begin
    bus.pad_d_i = '0; bus.pad_vld_i = 1'b0; bus.pad_lst_i = 1'b0; bus.blk_rdy_i = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_blk_d", bus.blk_d_o, '0);
    rst = 1'b0;
    bus.blk_rdy_i = 1'b1;
    tick();

    // "abc": one block, last
    send_abc();
    repeat (3) tick();

    // 64-byte message: two blocks, second is the pure padding block
    wait_ena();
    for (int i = 0; i < BEATS; i++) beat({$urandom, $urandom}, 1'b0);
    beat(64'h8000000000000000, 1'b0);
    for (int i = 1; i < BEATS-1; i++) beat('0, 1'b0);
    beat(64'h200, 1'b1);
    chk("pad_d", bus.blk_d_o, PAD_BLK);
    chk("pad_lst", SM3_BLK_W'(bus.blk_lst_o), SM3_BLK_W'(1));
    repeat (3) tick();

    // back-pressure: two blocks fill both buffers, third waits for ready
    bus.blk_rdy_i = 1'b0;
    rand_blk(1'b0);
    rand_blk(1'b0);
    chk("bp_ena_low", SM3_BLK_W'(bus.pad_ena_o), SM3_BLK_W'(0));
    chk("bp_no_ovf", SM3_BLK_W'(bus.err_ovf_o), SM3_BLK_W'(0));
    repeat (3) tick();
    bus.blk_rdy_i = 1'b1;
    rand_blk(1'b1);
    repeat (4) tick();

    // misplaced last beat on beat 5: closed early with zero tail
    wait_ena();
    for (int i = 0; i < 5; i++) beat({$urandom, $urandom}, 1'b0);
    beat({$urandom, $urandom}, 1'b1);
    chk("algn_err", SM3_BLK_W'(bus.err_algn_o), SM3_BLK_W'(1));
    chk("algn_lst", SM3_BLK_W'(bus.blk_lst_o), SM3_BLK_W'(1));
    chk("algn_tail", SM3_BLK_W'(bus.blk_d_o[127:0]), '0);
    tick();
    send_abc();
    repeat (3) tick();

    // overflow: beat forced while both buffers are FULL
    bus.blk_rdy_i = 1'b0;
    rand_blk(1'b0);
    rand_blk(1'b1);
    beat({$urandom, $urandom}, 1'b0);
    chk("ovf_err", SM3_BLK_W'(bus.err_ovf_o), SM3_BLK_W'(1));
    repeat (2) tick();
    bus.blk_rdy_i = 1'b1;
    repeat (4) tick();

    // reset mid-fill, then a clean message
    wait_ena();
    for (int i = 0; i < 3; i++) beat({$urandom, $urandom}, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst_mid_d", bus.blk_d_o, '0);
    chk("rst_mid_ena", SM3_BLK_W'(bus.pad_ena_o), SM3_BLK_W'(0));
    rst = 1'b0;
    tick();
    send_abc();
    repeat (3) tick();

    // randomized traffic, mostly honouring pad_ena at block starts
    for (int n = 0; n < 1500; n++) begin
      bus.blk_rdy_i = 1'($urandom_range(0, 2) != 0);
      if (mcnt == 0 && !bus.pad_ena_o && $urandom_range(0, 7) != 0) begin
        bus.pad_vld_i = 1'b0;
        bus.pad_lst_i = 1'b0;
      end else begin
        bus.pad_vld_i = 1'($urandom_range(0, 3) != 0);
        bus.pad_d_i   = {$urandom, $urandom};
        bus.pad_lst_i = (mcnt == BEATS-1) ? 1'($urandom_range(0, 1))
                                          : 1'($urandom_range(0, 39) == 0);
      end
      tick();
    end
    bus.pad_vld_i = 1'b0; bus.pad_lst_i = 1'b0; bus.blk_rdy_i = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
